// File: rtl/decode_queue_pkg.sv
// MIPS ISA constants, flag bit positions and the decoded-entry layout shared by
// the instruction decoder and the decode queue.
package decode_queue_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL function codes
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  // REGIMM rt codes
  localparam logic [4:0] RI_BLTZ    = 5'h00;
  localparam logic [4:0] RI_BGEZ    = 5'h01;

  // Flag vector layout: {illegal, branch, mem, shift, imm, unsigned}
  localparam int unsigned FLAG_W        = 6;
  localparam int unsigned FLAG_UNSIGNED = 0;
  localparam int unsigned FLAG_IMM      = 1;
  localparam int unsigned FLAG_SHIFT    = 2;
  localparam int unsigned FLAG_MEM      = 3;
  localparam int unsigned FLAG_BRANCH   = 4;
  localparam int unsigned FLAG_ILLEGAL  = 5;

  typedef logic [FLAG_W-1:0] flags_t;

  typedef enum logic [2:0] {
    CL_ILLEGAL,
    CL_BRANCH,
    CL_ARITH_U,
    CL_SHIFT_IMM,
    CL_SHIFT_VAR,
    CL_MEM,
    CL_IMM,
    CL_IMM_U
  } instr_class_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [5:0]  op_type;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh_amt;
    logic [31:0] imm;
    logic [25:0] target;
    flags_t      flags;
  } decoded_t;

  function automatic flags_t class_flags(input instr_class_e cls);
    flags_t f;
    f = '0;
    case (cls)
      CL_BRANCH:    f[FLAG_BRANCH] = 1'b1;
      CL_ARITH_U:   f[FLAG_UNSIGNED] = 1'b1;
      CL_SHIFT_IMM: begin
        f[FLAG_SHIFT] = 1'b1;
        f[FLAG_IMM]   = 1'b1;
      end
      CL_SHIFT_VAR: f[FLAG_SHIFT] = 1'b1;
      CL_MEM: begin
        f[FLAG_MEM] = 1'b1;
        f[FLAG_IMM] = 1'b1;
      end
      CL_IMM:       f[FLAG_IMM] = 1'b1;
      CL_IMM_U: begin
        f[FLAG_IMM]      = 1'b1;
        f[FLAG_UNSIGNED] = 1'b1;
      end
      default:      f[FLAG_ILLEGAL] = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/decode_queue_instr_decode.sv
// Purely combinational MIPS decoder: classifies the raw word and produces the
// field/immediate/flag bundle stored in each queue entry.
module instr_decode
  import decode_queue_pkg::*;
(
  input  logic [31:0] instr_32,
  output decoded_t    dec
);

  logic [5:0]   opcode;
  logic [5:0]   func;
  logic [4:0]   rt;
  logic [15:0]  imm16;
  instr_class_e cls;
  logic [31:0]  imm_ext;
  logic [5:0]   op_type;

  assign opcode = instr_32[31:26];
  assign func   = instr_32[5:0];
  assign rt     = instr_32[20:16];
  assign imm16  = instr_32[15:0];

  always_comb begin
    cls = CL_ILLEGAL;
    case (opcode)
      OP_SPECIAL: begin
        case (func)
          FN_JR, FN_JALR:                                cls = CL_BRANCH;
          FN_ADDU, FN_SUBU, FN_MULTU, FN_DIVU, FN_SLTU: cls = CL_ARITH_U;
          FN_SLL, FN_SRL, FN_SRA:                        cls = CL_SHIFT_IMM;
          FN_SLLV, FN_SRLV, FN_SRAV:                     cls = CL_SHIFT_VAR;
          default:                                       cls = CL_ILLEGAL;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RI_BLTZ, RI_BGEZ: cls = CL_BRANCH;
          default:          cls = CL_ILLEGAL;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls = CL_BRANCH;
      OP_ADDIU, OP_SLTIU:                             cls = CL_IMM_U;
      OP_SLTI, OP_ORI, OP_XORI:                       cls = CL_IMM;
      OP_LW, OP_SW, OP_LB, OP_LBU, OP_SB, OP_LUI:     cls = CL_MEM;
      default:                                        cls = CL_ILLEGAL;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_ORI, OP_XORI: imm_ext = {16'h0000, imm16};
      OP_LUI:          imm_ext = {imm16, 16'h0000};
      default:         imm_ext = {{16{imm16[15]}}, imm16};
    endcase
  end

  always_comb begin
    case (opcode)
      OP_SPECIAL: op_type = func;
      OP_REGIMM:  op_type = {1'b0, rt};
      default:    op_type = opcode;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.instr   = instr_32;
    dec.op_type = op_type;
    dec.rs      = instr_32[25:21];
    dec.rt      = rt;
    dec.rd      = instr_32[15:11];
    dec.sh_amt  = instr_32[10:6];
    dec.imm     = imm_ext;
    dec.target  = instr_32[25:0];
    dec.flags   = class_flags(cls);
  end

endmodule

// File: rtl/decode_queue.sv
// Decode queue: decodes at the write port and buffers decoded entries in a
// DEPTH-entry FIFO; head outputs come straight from storage.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     w_clock,
  input  logic                     w_reset_n,
  input  logic                     w_flush,
  input  logic                     w_in_valid,
  output logic                     w_in_ready,
  input  logic [31:0]              w_instr_32,
  input  logic [PC_W-1:0]          w_pc,
  output logic                     w_out_valid,
  input  logic                     w_out_ready,
  output logic [PC_W-1:0]          w_out_pc,
  output logic [31:0]              w_out_instr_32,
  output logic [5:0]               w_op_type_6,
  output logic [4:0]               w_rs_addr_5,
  output logic [4:0]               w_rt_addr_5,
  output logic [4:0]               w_rd_addr_5,
  output logic [4:0]               w_sh_amt_5,
  output logic [31:0]              w_imm_32,
  output logic [25:0]              w_branch_imm_val_26,
  output logic [5:0]               w_flags_6,
  output logic [$clog2(DEPTH):0]   w_count,
  output logic [CNT_W-1:0]         w_illegal_cnt
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  decoded_t        dec;
  decoded_t        mem_dec [DEPTH];
  logic [PC_W-1:0] mem_pc  [DEPTH];
  decoded_t        head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [AW:0]     count_nxt;
  logic [CNT_W-1:0] illegal_cnt;
  logic            push;
  logic            pop;

  instr_decode u_instr_decode (
    .instr_32 (w_instr_32),
    .dec      (dec)
  );

  // Ready depends only on the registered count, never on w_out_ready.
  assign w_in_ready  = (count < FULL);
  assign w_out_valid = (count != '0);
  assign push        = w_in_valid && w_in_ready && !w_flush;
  assign pop         = w_out_valid && w_out_ready && !w_flush;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage is reset so the head reads as zero while reset is held.
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_dec[AW'(i)] <= '0;
        mem_pc[AW'(i)]  <= '0;
      end
    end else if (push) begin
      mem_dec[wr_ptr] <= dec;
      mem_pc[wr_ptr]  <= w_pc;
    end
  end

  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (w_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  // Flush does not clear this counter; a flushed push never counts.
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      illegal_cnt <= '0;
    end else if (push && dec.flags[FLAG_ILLEGAL] && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  assign head                = mem_dec[rd_ptr];
  assign w_out_pc            = mem_pc[rd_ptr];
  assign w_out_instr_32      = head.instr;
  assign w_op_type_6         = head.op_type;
  assign w_rs_addr_5         = head.rs;
  assign w_rt_addr_5         = head.rt;
  assign w_rd_addr_5         = head.rd;
  assign w_sh_amt_5          = head.sh_amt;
  assign w_imm_32            = head.imm;
  assign w_branch_imm_val_26 = head.target;
  assign w_flags_6           = head.flags;
  assign w_count             = count;
  assign w_illegal_cnt       = illegal_cnt;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: directed scenarios plus random traffic
// checked against a behavioural MIPS decode and queue model.
module tb_decode_queue;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned ILL_MAX = (1 << CNT_W) - 1;

  logic                   clk       = 1'b0;
  logic                   rst_n     = 1'b1;
  logic                   flush     = 1'b0;
  logic                   in_valid  = 1'b0;
  logic                   out_ready = 1'b0;
  logic [31:0]            instr     = '0;
  logic [PC_W-1:0]        pc        = '0;
  logic                   in_ready;
  logic                   out_valid;
  logic [PC_W-1:0]        out_pc;
  logic [31:0]            out_instr;
  logic [5:0]             op_type;
  logic [4:0]             rs_a, rt_a, rd_a, sh_a;
  logic [31:0]            imm;
  logic [25:0]            bimm;
  logic [5:0]             flags;
  logic [$clog2(DEPTH):0] count;
  logic [CNT_W-1:0]       ill_cnt;

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .w_clock             (clk),
    .w_reset_n           (rst_n),
    .w_flush             (flush),
    .w_in_valid          (in_valid),
    .w_in_ready          (in_ready),
    .w_instr_32          (instr),
    .w_pc                (pc),
    .w_out_valid         (out_valid),
    .w_out_ready         (out_ready),
    .w_out_pc            (out_pc),
    .w_out_instr_32      (out_instr),
    .w_op_type_6         (op_type),
    .w_rs_addr_5         (rs_a),
    .w_rt_addr_5         (rt_a),
    .w_rd_addr_5         (rd_a),
    .w_sh_amt_5          (sh_a),
    .w_imm_32            (imm),
    .w_branch_imm_val_26 (bimm),
    .w_flags_6           (flags),
    .w_count             (count),
    .w_illegal_cnt       (ill_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic [5:0]      op;
    logic [4:0]      rs, rt, rd, sh;
    logic [31:0]     imm;
    logic [25:0]     tgt;
    logic [5:0]      flags;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned mon_n;
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned m_ill = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decode from the instruction-set tables, using integer arithmetic.
  function automatic exp_t ref_model(input logic [31:0] w, input logic [PC_W-1:0] p);
    exp_t e;
    int op, fn, rt, imm16;
    bit br, un, sh, mm, im, legal;
    op = int'(w[31:26]); fn = int'(w[5:0]); rt = int'(w[20:16]); imm16 = int'(w[15:0]);
    br = 0; un = 0; sh = 0; mm = 0; im = 0; legal = 1;
    if (op == 0) begin
      case (fn)
        8, 9:                         br = 1;
        'h21, 'h23, 'h19, 'h1B, 'h2B: un = 1;
        0, 2, 3:                      begin sh = 1; im = 1; end
        4, 6, 7:                      sh = 1;
        default:                      legal = 0;
      endcase
    end else if (op == 1) begin
      legal = (rt == 0) || (rt == 1);
      br    = legal;
    end else begin
      case (op)
        2, 3, 4, 5, 6, 7:                   br = 1;
        'h09, 'h0B:                         begin im = 1; un = 1; end
        'h0A, 'h0D, 'h0E:                   im = 1;
        'h23, 'h2B, 'h20, 'h24, 'h28, 'h0F: begin mm = 1; im = 1; end
        default:                            legal = 0;
      endcase
    end
    e.instr = w;
    e.pc    = p;
    e.op    = (op == 0) ? 6'(fn) : (op == 1) ? 6'(rt) : 6'(op);
    e.rs    = w[25:21];
    e.rt    = w[20:16];
    e.rd    = w[15:11];
    e.sh    = w[10:6];
    e.tgt   = w[25:0];
    if (op == 'h0D || op == 'h0E) e.imm = 32'(imm16);
    else if (op == 'h0F)          e.imm = 32'(longint'(imm16) * 65536);
    else                          e.imm = 32'((imm16 >= 32768) ? imm16 - 65536 : imm16);
    e.flags = legal ? {1'b0, br, mm, sh, im, un} : 6'b100000;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  ops [10];
    ops = '{6'h02, 6'h03, 6'h04, 6'h09, 6'h0A, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h28};
    w = $urandom();
    case ($urandom_range(0, 3))
      1: w[31:26] = ops[$urandom_range(0, 9)];
      2: begin
        w[31:26] = 6'h00;
        w[5:0]   = 6'($urandom_range(0, 47));
      end
      3: begin
        w[31:26] = 6'h01;
        w[20:16] = 5'($urandom_range(0, 3));
      end
      default: ;
    endcase
    return w;
  endfunction

  // Monitor: inputs change at posedge+1, so negedge sees what the next edge will act on.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_ill = 0;
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_ill_cnt", ill_cnt, 0);
      chk("rst_head_pc", out_pc, 0);
      chk("rst_head_instr", out_instr, 0);
      chk("rst_head_imm", imm, 0);
      chk("rst_head_flags", flags, 0);
    end else begin
      mon_n = sb.size();
      chk("count", count, mon_n);
      chk("in_ready", in_ready, mon_n < DEPTH);
      chk("out_valid", out_valid, mon_n > 0);
      chk("ill_cnt", ill_cnt, m_ill);
      if (mon_n > 0) begin
        chk("head_pc", out_pc, sb[0].pc);
        chk("head_instr", out_instr, sb[0].instr);
        chk("head_op", op_type, sb[0].op);
        chk("head_rs", rs_a, sb[0].rs);
        chk("head_rt", rt_a, sb[0].rt);
        chk("head_rd", rd_a, sb[0].rd);
        chk("head_sh", sh_a, sb[0].sh);
        chk("head_imm", imm, sb[0].imm);
        chk("head_target", bimm, sb[0].tgt);
        chk("head_flags", flags, sb[0].flags);
      end
      if (flush) begin
        sb.delete();
      end else begin
        if (mon_n > 0 && out_ready) void'(sb.pop_front());
        if (mon_n < DEPTH && in_valid) begin
          mon_e = ref_model(instr, pc);
          sb.push_back(mon_e);
          if (mon_e.flags[5] && m_ill < ILL_MAX) m_ill++;
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // ADDIU with all-ones immediate
    in_valid = 1'b1; instr = 32'h2408FFFF; pc = 32'h100;
    step();
    in_valid = 1'b0;
    chk("r37_valid", out_valid, 1);
    chk("r37_op", op_type, 6'h09);
    chk("r37_imm", imm, 32'hFFFFFFFF);
    chk("r37_flags", flags, 6'b000011);
    chk("r37_pc", out_pc, 32'h100);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // ORI zero-extends, LUI shifts up
    in_valid = 1'b1; instr = 32'h3508FFFF; pc = 32'h104; step();
    instr = 32'h3C081234; pc = 32'h108; step();
    in_valid = 1'b0;
    chk("r38_ori_imm", imm, 32'h0000FFFF);
    out_ready = 1'b1; step();
    chk("r38_lui_imm", imm, 32'h12340000);
    chk("r38_lui_flags", flags, 6'b001010);
    step(); out_ready = 1'b0;

    // Fill past capacity, then drain in order
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; instr = {16'h2400, 16'(i)}; pc = 32'h200 + 32'(4 * i);
      step();
    end
    in_valid = 1'b0;
    chk("r39_in_ready", in_ready, 0);
    chk("r39_count", count, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("r39_drain_pc", out_pc, 32'h200 + 32'(4 * i));
      step();
    end
    out_ready = 1'b0;
    chk("r39_empty", out_valid, 0);

    // Full queue with continuous push and pop
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; instr = {16'h2410, 16'(i)}; pc = 32'h400 + 32'(4 * i);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      instr = {16'h2420, 16'(i)}; pc = 32'h500 + 32'(4 * i);
      step();
      chk("r40_count_range", (count == 3) || (count == 4), 1);
    end
    in_valid = 1'b0;
    repeat (5) step();
    out_ready = 1'b0;
    chk("r40_drained", count, 0);

    // Flush beats a concurrent push
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; instr = {16'h2430, 16'(i)}; pc = 32'h600 + 32'(4 * i);
      step();
    end
    flush = 1'b1; instr = 32'h2408DEAD; pc = 32'hDEAD0000;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("r41_count", count, 0);
    chk("r41_valid", out_valid, 0);
    in_valid = 1'b1; instr = 32'h24090001; pc = 32'h700; step();
    in_valid = 1'b0;
    chk("r41_next_pc", out_pc, 32'h700);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Illegal counter saturates at 3 with CNT_W=2
    chk("r42_ill_start", ill_cnt, 0);
    in_valid = 1'b1; instr = 32'hFC000000;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h800 + 32'(4 * i);
      step();
    end
    in_valid = 1'b0;
    chk("r42_cnt", ill_cnt, 3);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("r42_flag", flags[5], 1);
      step();
    end
    in_valid = 1'b1;
    repeat (2) step();
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("r42_sat", ill_cnt, 3);

    // Asynchronous reset mid-operation
    in_valid = 1'b1; instr = 32'h24080005;
    repeat (2) step();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ill", ill_cnt, 0);
    chk("mid_rst_ready", in_ready, 1);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      instr     = rand_instr();
      pc        = $urandom();
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 2) step();
    chk("final_empty", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
